// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives a variable-latency instruction memory,
// buffers up to two fetched words for decode and applies downstream redirects and HALT.
module fetch_sequencer #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_done,
  input  logic [15:0]     imem_data,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            stall,
  input  logic            halt,
  output logic            if_valid,
  output logic [15:0]     if_instr,
  output logic [PC_W-1:0] if_pc_plus2,
  output logic            halted
);

  localparam logic [15:0] Nop = 16'h0800;

  typedef enum logic [2:0] {StStart, StIdle, StBusy, StDiscard, StHalted} state_e;

  state_e                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [PC_W-1:0]        req_addr_q, req_addr_d;
  logic                   halt_pend_q, halt_pend_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [1:0][15:0]       instr_q, instr_d;
  logic [1:0][PC_W-1:0]   pcp2_q, pcp2_d;

  logic                   pop, push, clear, outstanding;
  logic [1:0]             cnt_ap;
  logic [PC_W-1:0]        addr_plus2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StStart;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      halt_pend_q <= 1'b0;
      cnt_q       <= 2'd0;
      instr_q     <= {Nop, Nop};
      pcp2_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      halt_pend_q <= halt_pend_d;
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      pcp2_q      <= pcp2_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    halt_pend_d = halt_pend_q;
    push        = 1'b0;
    clear       = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = pc_q;

    pop         = (cnt_q != 2'd0) && !stall;
    cnt_ap      = cnt_q - {1'b0, pop};
    outstanding = (state_q == StBusy) || (state_q == StDiscard);

    case (state_q)
      StIdle:            imem_req = (cnt_ap < 2'd2) && !redirect_valid && !halt;
      StBusy, StDiscard: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
      end
      default: ;
    endcase

    addr_plus2 = imem_addr + PC_W'(2);

    case (state_q)
      StStart: state_d = StIdle;
      StIdle, StBusy, StDiscard: begin
        if (redirect_valid) begin
          // Redirect beats halt and stall; a HALT seen alongside it is wrong-path.
          pc_d  = redirect_pc;
          clear = 1'b1;
          if (outstanding && !imem_done) begin
            state_d = StDiscard;
          end else if (state_q == StDiscard && halt_pend_q) begin
            state_d     = StHalted;
            halt_pend_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else if (halt) begin
          clear = 1'b1;
          if (outstanding && !imem_done) begin
            state_d     = StDiscard;
            halt_pend_d = 1'b1;
          end else begin
            state_d     = StHalted;
            halt_pend_d = 1'b0;
          end
        end else begin
          case (state_q)
            StIdle: begin
              if (imem_req) begin
                if (imem_done) begin
                  push = 1'b1;
                  pc_d = addr_plus2;
                end else begin
                  req_addr_d = pc_q;
                  state_d    = StBusy;
                end
              end
            end
            StBusy: begin
              if (imem_done) begin
                push    = 1'b1;
                pc_d    = addr_plus2;
                state_d = StIdle;
              end
            end
            default: begin
              if (imem_done) begin
                state_d     = halt_pend_q ? StHalted : StIdle;
                halt_pend_d = 1'b0;
              end
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  // Two-entry shift FIFO; entry 0 is the head presented to decode.
  always_comb begin
    cnt_d   = cnt_q;
    instr_d = instr_q;
    pcp2_d  = pcp2_q;
    if (clear) begin
      cnt_d = 2'd0;
    end else begin
      if (pop) begin
        instr_d[0] = instr_q[1];
        pcp2_d[0]  = pcp2_q[1];
        cnt_d      = cnt_ap;
      end
      if (push) begin
        instr_d[cnt_ap[0]] = imem_data;
        pcp2_d[cnt_ap[0]]  = addr_plus2;
        cnt_d              = cnt_ap + 2'd1;
      end
    end
  end

  assign if_valid    = (cnt_q != 2'd0);
  assign if_instr    = instr_q[0];
  assign if_pc_plus2 = pcp2_q[0];
  assign halted      = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a wait-state memory that returns the address as data.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus2;
  logic        halted;

  int checks = 0;
  int failures = 0;
  int mem_wait = 0;
  int wcnt = 0;

  fetch_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_done      (imem_done),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .halt           (halt),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc_plus2    (if_pc_plus2),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  assign imem_done = imem_req && (wcnt == mem_wait);
  assign imem_data = imem_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (imem_req && !imem_done) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, 32'(imem_req), 32'd0);
    check_eq({tag, "_addr"}, 32'(imem_addr), 32'h0000);
    check_eq({tag, "_valid"}, 32'(if_valid), 32'd0);
    check_eq({tag, "_instr"}, 32'(if_instr), 32'h0800);
    check_eq({tag, "_pcp2"}, 32'(if_pc_plus2), 32'h0000);
    check_eq({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  // Returns at the release point; the first IDLE cycle is one tick later.
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    halt = 1'b0;
    stall = 1'b0;
    mem_wait = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // Reset values and zero-wait streaming.
    @(negedge clk);
    #1 check_reset_outputs("rst");
    do_reset();
    #1 check_eq("start_req", 32'(imem_req), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      #1;
      check_eq($sformatf("zw_addr%0d", c), 32'(imem_addr), 32'(2 * (c - 1)));
      check_eq($sformatf("zw_req%0d", c), 32'(imem_req), 32'd1);
      if (c > 1) begin
        check_eq($sformatf("zw_valid%0d", c), 32'(if_valid), 32'd1);
        check_eq($sformatf("zw_instr%0d", c), 32'(if_instr), 32'(2 * (c - 2)));
        check_eq($sformatf("zw_pcp2%0d", c), 32'(if_pc_plus2), 32'(2 * (c - 1)));
      end
    end

    // Three wait states: request held four cycles, one instruction every four.
    do_reset();
    mem_wait = 3;
    for (int c = 1; c <= 12; c++) begin
      tick();
      #1;
      check_eq($sformatf("w3_req%0d", c), 32'(imem_req), 32'd1);
      check_eq($sformatf("w3_addr%0d", c), 32'(imem_addr), 32'(((c - 1) / 4) * 2));
      check_eq($sformatf("w3_valid%0d", c), 32'(if_valid),
               32'((c >= 5) && ((c - 1) % 4 == 0)));
    end

    // Stall fills the buffer, request drops, then drains without loss.
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      tick();
      stall = (c <= 5);
      #1;
      if (c == 2) begin
        check_eq("st_valid2", 32'(if_valid), 32'd1);
        check_eq("st_instr2", 32'(if_instr), 32'h0000);
        check_eq("st_addr2", 32'(imem_addr), 32'h0002);
      end else if (c >= 3 && c <= 5) begin
        check_eq($sformatf("st_req%0d", c), 32'(imem_req), 32'd0);
        check_eq($sformatf("st_instr%0d", c), 32'(if_instr), 32'h0000);
      end else if (c >= 6) begin
        check_eq($sformatf("st_req%0d", c), 32'(imem_req), 32'd1);
        check_eq($sformatf("st_instr%0d", c), 32'(if_instr), 32'(2 * (c - 6)));
        check_eq($sformatf("st_addr%0d", c), 32'(imem_addr), 32'(2 * (c - 6) + 4));
      end
    end
    stall = 1'b0;

    // Redirect while a slow request to 0x0006 is outstanding.
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 4) mem_wait = 3;
      redirect_valid = (c == 5);
      redirect_pc    = 16'h0040;
      #1;
      case (c)
        4: begin
          check_eq("rd_addr4", 32'(imem_addr), 32'h0006);
          check_eq("rd_instr4", 32'(if_instr), 32'h0004);
        end
        5: check_eq("rd_addr5", 32'(imem_addr), 32'h0006);
        6, 7: begin
          check_eq($sformatf("rd_addr%0d", c), 32'(imem_addr), 32'h0006);
          check_eq($sformatf("rd_valid%0d", c), 32'(if_valid), 32'd0);
        end
        8, 11: begin
          check_eq($sformatf("rd_addr%0d", c), 32'(imem_addr), 32'h0040);
          check_eq($sformatf("rd_req%0d", c), 32'(imem_req), 32'd1);
          check_eq($sformatf("rd_valid%0d", c), 32'(if_valid), 32'd0);
        end
        12: begin
          check_eq("rd_valid12", 32'(if_valid), 32'd1);
          check_eq("rd_instr12", 32'(if_instr), 32'h0040);
          check_eq("rd_pcp2_12", 32'(if_pc_plus2), 32'h0042);
        end
        default: ;
      endcase
    end
    redirect_valid = 1'b0;
    mem_wait = 0;

    // Halt together with redirect is ignored; a lone halt freezes fetch.
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      tick();
      redirect_valid = (c == 2);
      redirect_pc    = 16'h0080;
      halt           = (c == 2) || (c == 4);
      #1;
      case (c)
        2: check_eq("hl_req2", 32'(imem_req), 32'd0);
        3: begin
          check_eq("hl_valid3", 32'(if_valid), 32'd0);
          check_eq("hl_halted3", 32'(halted), 32'd0);
          check_eq("hl_addr3", 32'(imem_addr), 32'h0080);
          check_eq("hl_req3", 32'(imem_req), 32'd1);
        end
        4: begin
          check_eq("hl_instr4", 32'(if_instr), 32'h0080);
          check_eq("hl_halted4", 32'(halted), 32'd0);
          check_eq("hl_req4", 32'(imem_req), 32'd0);
        end
        5, 6, 7, 8, 9: begin
          check_eq($sformatf("hl_halted%0d", c), 32'(halted), 32'd1);
          check_eq($sformatf("hl_req%0d", c), 32'(imem_req), 32'd0);
          check_eq($sformatf("hl_valid%0d", c), 32'(if_valid), 32'd0);
        end
        default: ;
      endcase
    end
    halt = 1'b0;
    redirect_valid = 1'b0;

    // PC wrap from 0xFFFE to 0x0000.
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    #1 check_eq("wr_addr", 32'(imem_addr), 32'hFFFE);
    tick();
    #1;
    check_eq("wr_next", 32'(imem_addr), 32'h0000);
    check_eq("wr_instr", 32'(if_instr), 32'hFFFE);
    check_eq("wr_pcp2", 32'(if_pc_plus2), 32'h0000);

    // Asynchronous reset in the middle of an outstanding request.
    do_reset();
    tick();
    tick();
    tick();
    mem_wait = 3;
    tick();
    #1 check_eq("ar_req_busy", 32'(imem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("ar");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequencer for the instruction-fetch stage of the 16-bit pipeline. It owns the PC and issues requests to a variable-latency instruction memory. It buffers up to two fetched instructions for decode and applies redirects (taken branches, J/JR/JAL/JALR) resolved downstream. It also freezes fetch when decode accepts HALT. It sits between the instruction memory and the IF/ID boundary, and consumes the Jump/Branch resolution results as a single redirect.

## Interface
- PC_W, 16, PC and address width
- RESET_PC, 16'h0000, PC value loaded at reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request; once raised, held with stable imem_addr until imem_done
- imem_addr  out  PC_W  fetch address
- imem_done  in  1  request complete this cycle (may coincide with the first imem_req cycle)
- imem_data  in  16  instruction word, valid when imem_done
- redirect_valid  in  1  downstream resolved taken branch/jump this cycle
- redirect_pc  in  PC_W  redirect target
- stall  in  1  decode cannot accept this cycle
- halt  in  1  decode accepted HALT (opcode 5'b00000) this cycle
- if_valid  out  1  buffer head valid
- if_instr  out  16  buffer head instruction
- if_pc_plus2  out  PC_W  fetch address of head + 2
- halted  out  1  fetch permanently frozen

## Operation
- **Buffer**
  - 2-entry FIFO of {instr, pc+2}.
  - Pop when if_valid && !stall.
  - Push only on imem_done in BUSY/IDLE; no push at count 2, by construction.
- **Registers**
  - pc: next address to fetch.
  - req_addr: address of the outstanding request.
- **States:** START, IDLE, BUSY, DISCARD, HALTED.
- **START** (reset state): imem_req=0; goes to IDLE on the next edge.
- **IDLE**
  - imem_req = (count_after_pop < 2); imem_addr = pc.
  - Issue with imem_done the same cycle: push, pc <= pc+2, stay IDLE.
  - Issue without imem_done: req_addr <= pc, go to BUSY.
- **BUSY**
  - imem_req=1, imem_addr=req_addr.
  - On imem_done: push, pc <= req_addr+2, go to IDLE.
- **DISCARD**
  - imem_req=1, imem_addr=req_addr.
  - On imem_done: data dropped, go to IDLE, or to HALTED if a halt is pending.
- **Redirect** (any state except START/HALTED)
  - pc <= redirect_pc; buffer cleared; any pop that cycle is ignored.
  - Outstanding request not completing this cycle: go to DISCARD.
  - Completing this cycle: drop its data and go to IDLE.
  - No new issue in the redirect cycle.
- **Halt**
  - Buffer cleared; no further issue.
  - No outstanding request: go to HALTED.
  - Outstanding request: DISCARD with halt pending, then HALTED.
  - HALTED exits only via reset.
- **Simultaneous events**
  - redirect_valid with halt: redirect wins, halt ignored (the HALT is wrong-path).
  - redirect_valid with stall: redirect wins.
  - Redirect while in DISCARD: pc updated, stay in DISCARD.
- **Arithmetic:** pc+2 modulo 2^PC_W; 0xFFFE wraps to 0x0000.
- **Reset values:** imem_req 0, imem_addr RESET_PC, if_valid 0, if_instr 16'h0800 (NOP), if_pc_plus2 0, halted 0; pc = RESET_PC; count 0.
- **Reset mid-request:** the request is abandoned; the memory must accept loss of imem_req.

## Timing
- First imem_req in the second cycle after rst_n rises (START lasts one cycle).
- Fetch latency: imem_done in cycle N gives if_valid with that instruction in cycle N+1.
- Zero-wait memory, no stall: one instruction per cycle.
- Memory with k wait cycles: one instruction per k+1 cycles (single outstanding request).
- Redirect in cycle N:
  - if_valid=0 in N+1.
  - Target requested in N+1 if no request is outstanding; otherwise in the cycle after the discarded request completes.
- halted rises the cycle after entering HALTED.
- imem_req is never dropped and imem_addr never changes while a request is outstanding.

## Test plan
- Reset release, zero-wait memory returning addr as data, stall=0 → imem_addr 0x0000, 0x0002, 0x0004 on consecutive cycles; if_instr follows one cycle later; if_pc_plus2 = 0x0002, 0x0004, ...
- 3-wait memory → imem_req held 4 cycles per address with addr stable; if_valid pulses once per 4 cycles.
- stall=1 for 5 cycles, zero-wait memory → count reaches 2, imem_req drops, if_instr held; on release, 2 pops then resumes with no lost or duplicated PC.
- Redirect to 0x0040 while a 3-wait request to 0x0006 is outstanding → DISCARD; 0x0006 data never appears; next request is to 0x0040 after the done; if_valid=0 in between.
- halt and redirect_valid in the same cycle → redirect taken, halted stays 0; a later lone halt → halted=1, imem_req stays 0 forever.
- pc 0xFFFE fetched → next address 0x0000; rst_n low mid-request → all outputs at reset values asynchronously.
